exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage of the 5-stage MIPS32 pipeline. It sits directly downstream of the decode stage and consumes its 160-bit bundle {IR, PC4, RS, RT, EXT}.
- It performs ALU operations, applies late forwarding on RS/RT, and owns the HI/LO registers with a single-cycle multiply and a 32-iteration divider.
- It hands {IR, PC4, AO, RT} to the memory stage using the same valid/allow_in/over handshake as the other stages.

Parameters:
- DIV_ITERS, 32: number of divider iterations; fixed at 32 for MIPS32.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cancel  in  1  flush; clears stage valid and aborts the divider
- id_over  in  1  decode stage holds a finished instruction
- mem_allow_in  in  1  memory stage can accept
- exe_allow_in  out  1  this stage can accept
- exe_over  out  1  this stage's instruction is finished
- exe_in  in  160  [159:128] IR, [127:96] PC4, [95:64] RS, [63:32] RT, [31:0] EXT
- exe_control  in  11  [10:7] alu_op, [6] alu_src_b (0 = RT, 1 = EXT), [5] shamt_sel (0 = IR[10:6], 1 = RS[4:0]), [4] link_sel (AO = PC4), [3:0] md_op
- forward_e  in  4  [3:2] RS select, [1:0] RT select: 0 latched, 1 ao_m, 2 rf_wdata_w, 3 latched
- ao_m  in  32  memory-stage ALU result
- rf_wdata_w  in  32  writeback data
- exe_out  out  128  [127:96] IR, [95:64] PC4, [63:32] AO, [31:0] forwarded RT (store data)
- pc4_e  out  32  latched PC4, used for decode-stage forwarding
- md_busy  out  1  divider is in the RUN or DONE state

Behaviour:
- Valid register: exe_allow_in = ~valid | (exe_over & mem_allow_in).
  - Latch exe_in and exe_control when exe_allow_in & id_over; valid <= 1.
  - Else if exe_over & mem_allow_in, valid <= 0.
  - cancel or reset forces valid <= 0 and wins over a simultaneous load.
- Reset values: valid 0, all latched fields 0, HI/LO 0, divider IDLE. Consequences: exe_out = 0, pc4_e = 0, exe_over = 0, exe_allow_in = 1, md_busy = 0.
- ALU (combinational on forwarded operands):
  - Operations: ADD, SUB (wrap-around, no trap), AND, OR, XOR, NOR, SLT (signed), SLTU, SLL, SRL, SRA, LUI (B << 16).
  - Shift amount is 5 bits.
  - Undefined alu_op gives AO = 0.
  - link_sel overrides the ALU: AO = PC4.
- md_op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; values 9-15 act as none.
- Latency:
  - Every non-divide op: exe_over = valid in the same cycle.
  - MULT/MULTU: 64-bit product computed in one cycle.
  - MTHI/MTLO: source is forwarded RS.
  - HI/LO are written only on the leave edge (exe_over & mem_allow_in).
  - MFHI/MFLO place HI or LO on AO.
- Divider FSM, IDLE -> RUN -> DONE -> IDLE:
  - IDLE -> RUN: valid & (DIV|DIVU) & ~cancel. Load |dividend| and |divisor| (signed ops), counter = 0.
  - RUN: one restoring step per cycle. After step DIV_ITERS-1, go to DONE.
  - DONE: apply sign fixes (quotient negative iff signs differ; remainder takes the dividend's sign); exe_over = 1. DONE -> IDLE on leave or cancel.
  - Instruction valid in cycle 0 gives exe_over first high in cycle 33.
- Divide by zero: LO = 0xFFFFFFFF, HI = dividend; the same 33-cycle timing applies.
- Cancel in RUN or DONE: return to IDLE next edge; HI/LO unchanged.
- Back-pressure: while mem_allow_in = 0 with exe_over high, exe_out stays stable and HI/LO are not written; DONE is held.
- Forwarding muxes are applied every cycle, so forwarded values may change while the stage is stalled.

Decomposition:
- Package exe_defs: alu_op and md_op encodings, divider state encoding, forward select codes, exe_in/exe_out field offsets.
- One sub-module, seq_divider:
  - Inputs: start, signed, a, b, cancel.
  - Outputs: busy, done, quot, rem.
  - Contains the FSM and counter.
- HI/LO, ALU and the handshake stay in exe_stage.

Test Plan:
- ADD, RS = 5, RT via forward_e = 01 with ao_m = 7 -> AO = 12 in the same cycle as valid; exe_over = 1.
- SLT with RS = 0xFFFFFFFF, RT = 1 -> AO = 1. SLTU with the same operands -> AO = 0.
- MULT 0xFFFFFFFF × 2 leaves; then MFHI -> 0xFFFFFFFF; MFLO -> 0xFFFFFFFE.
- DIV -7 / 2 -> exe_over first at cycle 33; after leaving, LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 7 / 0 -> LO = 0xFFFFFFFF, HI = 7.
- DIV, then cancel at cycle 10 -> valid = 0 and md_busy = 0 next cycle; HI/LO unchanged; a new ADD is accepted immediately.
- mem_allow_in held 0 for 5 cycles on a finished SUB -> exe_allow_in = 0, exe_out constant. Reset asserted mid-divide -> all outputs return to their reset values next edge.

Source files
------------

// File: rtl/exe_defs.sv
// Shared encodings for the execute stage: ALU/MD opcodes, divider states,
// forwarding selects and bundle field offsets.
package exe_defs;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Forwarding select codes; 0 and 3 both keep the latched operand.
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // exe_in field offsets (each field is 32 bits wide).
  localparam int IN_IR_LSB  = 128;
  localparam int IN_PC4_LSB = 96;
  localparam int IN_RS_LSB  = 64;
  localparam int IN_RT_LSB  = 32;
  localparam int IN_EXT_LSB = 0;

  // exe_out field offsets.
  localparam int OUT_IR_LSB  = 96;
  localparam int OUT_PC4_LSB = 64;
  localparam int OUT_AO_LSB  = 32;
  localparam int OUT_RT_LSB  = 0;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle. Works on magnitudes and
// applies MIPS sign rules when presenting the result in DONE.
module seq_divider
  import exe_defs::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  localparam int CW = $clog2(DIV_ITERS);
  localparam logic [CW-1:0] LAST = CW'(DIV_ITERS - 1);

  div_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [31:0] rem_q, quot_q, dsr_q;
  logic        q_neg_q, r_neg_q, b_zero_q;
  logic [32:0] r_sh, diff;
  logic [31:0] a_mag, b_mag;

  assign a_mag = (signed_op && a[31]) ? -a : a;
  assign b_mag = (signed_op && b[31]) ? -b : b;

  // One restoring step: shift in the next dividend bit and trial-subtract.
  assign r_sh = {rem_q, quot_q[31]};
  assign diff = r_sh - {1'b0, dsr_q};

  // Next-state logic for IDLE -> RUN -> DONE -> IDLE.
  // NOTE: every always_comb assigns its outputs a default first so no path leaves them unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_IDLE: if (start && !cancel) state_d = DIV_RUN;
      DIV_RUN: begin
        if (cancel)              state_d = DIV_IDLE;
        else if (cnt_q == LAST)  state_d = DIV_DONE;
      end
      DIV_DONE: if (cancel) state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  // State register plus operand load on start and one step per RUN cycle.
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dsr_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DIV_IDLE && start && !cancel) begin
        cnt_q    <= '0;
        rem_q    <= '0;
        quot_q   <= a_mag;
        dsr_q    <= b_mag;
        q_neg_q  <= signed_op & (a[31] ^ b[31]);
        r_neg_q  <= signed_op & a[31];
        b_zero_q <= (b == 32'd0);
      end else if (state_q == DIV_RUN) begin
        cnt_q  <= cnt_q + 1'b1;
        rem_q  <= diff[32] ? r_sh[31:0] : diff[31:0];
        quot_q <= {quot_q[30:0], ~diff[32]};
      end
    end
  end

  // With a zero divisor the remainder path already reproduces the dividend;
  // only the quotient needs forcing to all ones.
  assign quot = b_zero_q ? 32'hFFFF_FFFF : (q_neg_q ? -quot_q : quot_q);
  assign rem  = r_neg_q ? -rem_q : rem_q;
  assign busy = (state_q != DIV_IDLE);
  assign done = (state_q == DIV_DONE);

endmodule

// File: rtl/exe_stage.sv
// MIPS32 execute stage: operand forwarding, ALU, HI/LO with single-cycle
// multiply and sequential divide, valid/allow_in/over handshake.
module exe_stage
  import exe_defs::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cancel,
  input  logic         id_over,
  input  logic         mem_allow_in,
  output logic         exe_allow_in,
  output logic         exe_over,
  input  logic [159:0] exe_in,
  input  logic [10:0]  exe_control,
  input  logic [3:0]   forward_e,
  input  logic [31:0]  ao_m,
  input  logic [31:0]  rf_wdata_w,
  output logic [127:0] exe_out,
  output logic [31:0]  pc4_e,
  output logic         md_busy
);

  logic         valid_q;
  logic [159:0] in_q;
  logic [10:0]  ctl_q;
  logic [31:0]  hi_q, lo_q;

  logic [31:0] ir, pc4, rs_q, rt_q, ext;
  logic [31:0] rs_fwd, rt_fwd, opb, alu_res, ao;
  logic [4:0]  shamt;
  alu_op_e     alu_op;
  md_op_e      md_op;
  logic        is_div, load, leave;
  logic        div_done, div_busy;
  logic [31:0] div_quot, div_rem;
  logic        mul_signed;
  logic [63:0] prod;

  assign ir   = in_q[IN_IR_LSB  +: 32];
  assign pc4  = in_q[IN_PC4_LSB +: 32];
  assign rs_q = in_q[IN_RS_LSB  +: 32];
  assign rt_q = in_q[IN_RT_LSB  +: 32];
  assign ext  = in_q[IN_EXT_LSB +: 32];

  assign alu_op = alu_op_e'(ctl_q[10:7]);
  assign md_op  = md_op_e'(ctl_q[3:0]);
  assign is_div = (md_op == MD_DIV) || (md_op == MD_DIVU);

  // Divides finish only once the divider reaches DONE; everything else is single-cycle.
  assign exe_over     = valid_q & (~is_div | div_done);
  assign leave        = exe_over & mem_allow_in;
  assign exe_allow_in = ~valid_q | leave;
  assign load         = exe_allow_in & id_over;

  // Stage valid and latched bundle; cancel beats a simultaneous load.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      in_q    <= '0;
      ctl_q   <= '0;
    end else if (cancel) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      in_q    <= exe_in;
      ctl_q   <= exe_control;
    end else if (leave) begin
      valid_q <= 1'b0;
    end
  end

  // Late forwarding onto RS/RT, re-evaluated every cycle including stalls.
  always_comb begin
    rs_fwd = rs_q;
    rt_fwd = rt_q;
    case (forward_e[3:2])
      FWD_MEM: rs_fwd = ao_m;
      FWD_WB:  rs_fwd = rf_wdata_w;
      default: rs_fwd = rs_q;
    endcase
    case (forward_e[1:0])
      FWD_MEM: rt_fwd = ao_m;
      FWD_WB:  rt_fwd = rf_wdata_w;
      default: rt_fwd = rt_q;
    endcase
  end

  assign opb   = ctl_q[6] ? ext : rt_fwd;
  assign shamt = ctl_q[5] ? rs_fwd[4:0] : ir[10:6];

  // ALU on forwarded operands; undefined opcodes produce zero.
  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:  alu_res = rs_fwd + opb;
      ALU_SUB:  alu_res = rs_fwd - opb;
      ALU_AND:  alu_res = rs_fwd & opb;
      ALU_OR:   alu_res = rs_fwd | opb;
      ALU_XOR:  alu_res = rs_fwd ^ opb;
      ALU_NOR:  alu_res = ~(rs_fwd | opb);
      ALU_SLT:  alu_res = {31'd0, $signed(rs_fwd) < $signed(opb)};
      ALU_SLTU: alu_res = {31'd0, rs_fwd < opb};
      ALU_SLL:  alu_res = opb << shamt;
      ALU_SRL:  alu_res = opb >> shamt;
      ALU_SRA:  alu_res = 32'($signed(opb) >>> shamt);
      ALU_LUI:  alu_res = opb << 16;
      default:  alu_res = '0;
    endcase
  end

  // Result select: link address, then HI/LO moves, then the ALU.
  always_comb begin
    ao = alu_res;
    if (ctl_q[4])               ao = pc4;
    else if (md_op == MD_MFHI)  ao = hi_q;
    else if (md_op == MD_MFLO)  ao = lo_q;
  end

  // One 64-bit multiplier serves both MULT and MULTU via conditional sign extension.
  assign mul_signed = (md_op == MD_MULT);
  assign prod = {{32{mul_signed & rs_fwd[31]}}, rs_fwd} * {{32{mul_signed & rt_fwd[31]}}, rt_fwd};

  // The divider returns to IDLE when its result leaves or the stage is flushed.
  seq_divider #(.DIV_ITERS(DIV_ITERS)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (valid_q & is_div & ~cancel),
    .signed_op (md_op == MD_DIV),
    .a         (rs_fwd),
    .b         (rt_fwd),
    .cancel    (cancel | leave),
    .busy      (div_busy),
    .done      (div_done),
    .quot      (div_quot),
    .rem       (div_rem)
  );

  // HI/LO commit only when the instruction actually leaves the stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (leave && !cancel) begin
      case (md_op)
        MD_MULT, MD_MULTU: {hi_q, lo_q} <= prod;
        MD_DIV, MD_DIVU: begin
          lo_q <= div_quot;
          hi_q <= div_rem;
        end
        MD_MTHI: hi_q <= rs_fwd;
        MD_MTLO: lo_q <= rs_fwd;
        default: ;
      endcase
    end
  end

  assign exe_out = {ir, pc4, ao, rt_fwd};
  assign pc4_e   = pc4;
  assign md_busy = div_busy;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed cases plus randomized
// instructions against a behavioural reference model of ALU and HI/LO.
module tb_exe_stage;
  import exe_defs::*;

  logic         clk = 1'b0;
  logic         reset, cancel, id_over, mem_allow_in;
  logic         exe_allow_in, exe_over, md_busy;
  logic [159:0] exe_in;
  logic [10:0]  exe_control;
  logic [3:0]   forward_e;
  logic [31:0]  ao_m, rf_wdata_w, pc4_e;
  logic [127:0] exe_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk          (clk),
    .reset        (reset),
    .cancel       (cancel),
    .id_over      (id_over),
    .mem_allow_in (mem_allow_in),
    .exe_allow_in (exe_allow_in),
    .exe_over     (exe_over),
    .exe_in       (exe_in),
    .exe_control  (exe_control),
    .forward_e    (forward_e),
    .ao_m         (ao_m),
    .rf_wdata_w   (rf_wdata_w),
    .exe_out      (exe_out),
    .pc4_e        (pc4_e),
    .md_busy      (md_busy)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [10:0] mk_ctl(input logic [3:0] alu, input logic srcb, input logic shs,
                                          input logic link, input logic [3:0] md);
    return {alu, srcb, shs, link, md};
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] lat,
                                       input logic [31:0] aom, input logic [31:0] wd);
    if (sel == 2'd1) return aom;
    if (sel == 2'd2) return wd;
    return lat;
  endfunction

  // Reference ALU written from the instruction semantics with plain integer arithmetic.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd7:  return (a < b) ? 32'd1 : 32'd0;
      4'd8:  return b << sh;
      4'd9:  return b >> sh;
      4'd10: return sb >>> sh;
      4'd11: return b * 32'd65536;
      default: return 32'd0;
    endcase
  endfunction

  // HI/LO update applied when an instruction leaves the stage.
  task automatic model_leave(input logic [3:0] md, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sp;
    longint unsigned ua, ub, up;
    int ia, ib;
    ia = a;
    ib = b;
    sa = ia;
    sb = ib;
    ua = a;
    ub = b;
    case (md)
      4'd1: begin sp = sa * sb; m_hi = sp[63:32]; m_lo = sp[31:0]; end
      4'd2: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; end
      4'd3, 4'd4: begin
        if (b == 32'd0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = a;
        end else if (md == 4'd3) begin
          sp = sa / sb; m_lo = sp[31:0];
          sp = sa % sb; m_hi = sp[31:0];
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      4'd7: m_hi = a;
      4'd8: m_lo = a;
      default: ;
    endcase
  endtask

  // Issue one instruction into an empty stage, check result and latency,
  // optionally hold mem_allow_in low for `stall` cycles, then let it leave.
  task automatic exec(input string tag, input logic [31:0] ir, input logic [31:0] pc4,
                      input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] ext,
                      input logic [10:0] ctl, input logic [3:0] fe, input logic [31:0] aom,
                      input logic [31:0] wd, input int stall);
    logic [31:0] rs_f, rt_f, b, ao;
    logic [4:0] sh;
    logic [3:0] md;
    logic [127:0] exp_out;
    int n, lat_exp;
    md   = ctl[3:0];
    rs_f = pick(fe[3:2], rs, aom, wd);
    rt_f = pick(fe[1:0], rt, aom, wd);
    b    = ctl[6] ? ext : rt_f;
    sh   = ctl[5] ? rs_f[4:0] : ir[10:6];
    if (ctl[4])          ao = pc4;
    else if (md == 4'd5) ao = m_hi;
    else if (md == 4'd6) ao = m_lo;
    else                 ao = ref_alu(ctl[10:7], rs_f, b, sh);
    exp_out = {ir, pc4, ao, rt_f};
    lat_exp = (md == 4'd3 || md == 4'd4) ? 33 : 0;

    exe_in       = {ir, pc4, rs, rt, ext};
    exe_control  = ctl;
    forward_e    = fe;
    ao_m         = aom;
    rf_wdata_w   = wd;
    mem_allow_in = (stall == 0);
    id_over      = 1'b1;
    @(posedge clk); #1;
    id_over = 1'b0;
    n = 0;
    while (!exe_over && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, n, lat_exp);
    check({tag, " exe_out"}, exe_out, exp_out);
    check({tag, " pc4_e"}, pc4_e, pc4);
    for (int i = 0; i < stall; i++) begin
      check({tag, " stall allow_in"}, exe_allow_in, 1'b0);
      @(posedge clk); #1;
      check({tag, " stall exe_over"}, exe_over, 1'b1);
      check({tag, " stall exe_out"}, exe_out, exp_out);
    end
    mem_allow_in = 1'b1;
    #1;
    check({tag, " allow_in"}, exe_allow_in, 1'b1);
    @(posedge clk); #1;
    model_leave(md, rs_f, rt_f);
    check({tag, " left"}, exe_over, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " exe_out"}, exe_out, 128'd0);
    check({tag, " pc4_e"}, pc4_e, 32'd0);
    check({tag, " exe_over"}, exe_over, 1'b0);
    check({tag, " allow_in"}, exe_allow_in, 1'b1);
    check({tag, " md_busy"}, md_busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; cancel = 1'b0; id_over = 1'b0; mem_allow_in = 1'b1;
    exe_in = '0; exe_control = '0; forward_e = 4'd0; ao_m = '0; rf_wdata_w = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    // Forwarding and compare operations.
    exec("add_fwd", 32'h0, 32'h100, 32'd5, 32'h33, 32'h0, mk_ctl(4'd0, 0, 0, 0, 4'd0), 4'b0001, 32'd7, 32'd0, 0);
    exec("slt", 32'h0, 32'h104, 32'hFFFF_FFFF, 32'd1, 32'h0, mk_ctl(4'd6, 0, 0, 0, 4'd0), 4'b0000, 32'd0, 32'd0, 0);
    exec("sltu", 32'h0, 32'h108, 32'hFFFF_FFFF, 32'd1, 32'h0, mk_ctl(4'd7, 0, 0, 0, 4'd0), 4'b0000, 32'd0, 32'd0, 0);
    exec("rs_wb_fwd", 32'h0, 32'h10C, 32'd1, 32'd2, 32'h0, mk_ctl(4'd1, 0, 0, 0, 4'd0), 4'b1000, 32'd0, 32'd50, 0);
    exec("sll_ir", 32'h0000_0100, 32'h110, 32'd0, 32'h8000_0001, 32'h0, mk_ctl(4'd8, 0, 0, 0, 4'd0), 4'b0000, 32'd0, 32'd0, 0);
    exec("sra_rs", 32'h0, 32'h114, 32'd35, 32'h8000_0000, 32'h0, mk_ctl(4'd10, 0, 1, 0, 4'd0), 4'b0000, 32'd0, 32'd0, 0);
    exec("lui", 32'h0, 32'h118, 32'd0, 32'd0, 32'h0000_ABCD, mk_ctl(4'd11, 1, 0, 0, 4'd0), 4'b0000, 32'd0, 32'd0, 0);
    exec("undef_op", 32'h0, 32'h11C, 32'd9, 32'd9, 32'h0, mk_ctl(4'd13, 0, 0, 0, 4'd0), 4'b0000, 32'd0, 32'd0, 0);
    exec("link", 32'h0, 32'h120, 32'd9, 32'd9, 32'h0, mk_ctl(4'd0, 0, 0, 1, 4'd0), 4'b0000, 32'd0, 32'd0, 0);

    // Multiply then read back.
    exec("mult", 32'h0, 32'h200, 32'hFFFF_FFFF, 32'd2, 32'h0, mk_ctl(4'd0, 0, 0, 0, 4'd1), 4'b0000, 32'd0, 32'd0, 0);
    exec("mfhi_mult", 32'h0, 32'h204, 32'd0, 32'd0, 32'h0, mk_ctl(4'd0, 0, 0, 0, 4'd5), 4'b0000, 32'd0, 32'd0, 0);
    exec("mflo_mult", 32'h0, 32'h208, 32'd0, 32'd0, 32'h0, mk_ctl(4'd0, 0, 0, 0, 4'd6), 4'b0000, 32'd0, 32'd0, 0);
    check("mult hi model", m_hi, 32'hFFFF_FFFF);
    check("mult lo model", m_lo, 32'hFFFF_FFFE);

    // Back-pressure on a finished SUB.
    exec("sub_stall", 32'h0, 32'h300, 32'd10, 32'd3, 32'h0, mk_ctl(4'd1, 0, 0, 0, 4'd0), 4'b0000, 32'd0, 32'd0, 5);

    // Signed divide and divide by zero.
    exec("div", 32'h0, 32'h400, 32'hFFFF_FFF9, 32'd2, 32'h0, mk_ctl(4'd0, 0, 0, 0, 4'd3), 4'b0000, 32'd0, 32'd0, 0);
    exec("mflo_div", 32'h0, 32'h404, 32'd0, 32'd0, 32'h0, mk_ctl(4'd0, 0, 0, 0, 4'd6), 4'b0000, 32'd0, 32'd0, 0);
    exec("mfhi_div", 32'h0, 32'h408, 32'd0, 32'd0, 32'h0, mk_ctl(4'd0, 0, 0, 0, 4'd5), 4'b0000, 32'd0, 32'd0, 0);
    check("div lo model", m_lo, 32'hFFFF_FFFD);
    check("div hi model", m_hi, 32'hFFFF_FFFF);
    exec("divu_zero", 32'h0, 32'h40C, 32'd7, 32'd0, 32'h0, mk_ctl(4'd0, 0, 0, 0, 4'd4), 4'b0000, 32'd0, 32'd0, 2);
    check("divu0 lo model", m_lo, 32'hFFFF_FFFF);
    check("divu0 hi model", m_hi, 32'd7);

    // Divide cancelled at cycle 10.
    exe_in = {32'h0, 32'h500, 32'd100, 32'd3, 32'h0};
    exe_control = mk_ctl(4'd0, 0, 0, 0, 4'd3);
    forward_e = 4'd0; mem_allow_in = 1'b1; id_over = 1'b1;
    @(posedge clk); #1;
    id_over = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    check("cancel busy before", md_busy, 1'b1);
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    check("cancel md_busy", md_busy, 1'b0);
    check("cancel exe_over", exe_over, 1'b0);
    check("cancel allow_in", exe_allow_in, 1'b1);
    exec("add_after_cancel", 32'h0, 32'h504, 32'd1, 32'd1, 32'h0, mk_ctl(4'd0, 0, 0, 0, 4'd0), 4'b0000, 32'd0, 32'd0, 0);
    exec("mfhi_cancel", 32'h0, 32'h508, 32'd0, 32'd0, 32'h0, mk_ctl(4'd0, 0, 0, 0, 4'd5), 4'b0000, 32'd0, 32'd0, 0);
    exec("mflo_cancel", 32'h0, 32'h50C, 32'd0, 32'd0, 32'h0, mk_ctl(4'd0, 0, 0, 0, 4'd6), 4'b0000, 32'd0, 32'd0, 0);

    // Randomized instruction mix.
    for (int k = 0; k < 150; k++) begin
      logic [3:0] md;
      md = 4'($urandom_range(0, 15));
      if ((md == 4'd3 || md == 4'd4) && $urandom_range(0, 3) != 0) md = 4'd0;
      exec("rand", $urandom, $urandom, $urandom, ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom, $urandom,
           mk_ctl(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0), md),
           4'($urandom_range(0, 15)), $urandom, $urandom, $urandom_range(0, 2));
    end
    exec("mfhi_rand", 32'h0, 32'h600, 32'd0, 32'd0, 32'h0, mk_ctl(4'd0, 0, 0, 0, 4'd5), 4'b0000, 32'd0, 32'd0, 0);
    exec("mflo_rand", 32'h0, 32'h604, 32'd0, 32'd0, 32'h0, mk_ctl(4'd0, 0, 0, 0, 4'd6), 4'b0000, 32'd0, 32'd0, 0);

    // Make HI/LO non-zero, then reset in the middle of a divide.
    exec("mthi", 32'h0, 32'h700, 32'h1234_5678, 32'd0, 32'h0, mk_ctl(4'd0, 0, 0, 0, 4'd7), 4'b0000, 32'd0, 32'd0, 0);
    exec("mtlo", 32'h0, 32'h704, 32'h8765_4321, 32'd0, 32'h0, mk_ctl(4'd0, 0, 0, 0, 4'd8), 4'b0000, 32'd0, 32'd0, 0);
    exe_in = {32'h0, 32'h708, 32'd100, 32'd7, 32'h0};
    exe_control = mk_ctl(4'd0, 0, 0, 0, 4'd4);
    forward_e = 4'd0; id_over = 1'b1;
    @(posedge clk); #1;
    id_over = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("mid_div_reset");
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    exec("mfhi_after_reset", 32'h0, 32'h800, 32'd0, 32'd0, 32'h0, mk_ctl(4'd0, 0, 0, 0, 4'd5), 4'b0000, 32'd0, 32'd0, 0);
    exec("mflo_after_reset", 32'h0, 32'h804, 32'd0, 32'd0, 32'h0, mk_ctl(4'd0, 0, 0, 0, 4'd6), 4'b0000, 32'd0, 32'd0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
